// File: rtl/prog_delay_pkg.sv
// Shared types and helpers for the programmable delay line.
// Optional second read port is enabled with the PDL_TAP_EN macro.
package prog_delay_pkg;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } pdl_state_e;

    // Pointer width for an n-entry buffer, never below one bit.
    function automatic int unsigned ptr_width(input int unsigned n);
        if (n <= 32'd2) begin
            return 32'd1;
        end
        return $clog2(n);
    endfunction

    function automatic int unsigned clamp(input int unsigned v,
                                          input int unsigned lo,
                                          input int unsigned hi);
        if (v < lo) begin
            return lo;
        end
        if (v > hi) begin
            return hi;
        end
        return v;
    endfunction

endpackage

// File: rtl/pdl_ram.sv
// Simple dual-port sample store with synchronous, read-first reads.
// With PDL_TAP_EN a second read port is added (1W2R).
module pdl_ram
    import prog_delay_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int ENTRIES = 1023,
    parameter int AW      = 10
) (
    input  logic             clk,
    input  logic             i_en,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
`ifdef PDL_TAP_EN
    input  logic [AW-1:0]    i_raddr2,
    output logic [WIDTH-1:0] o_rdata2,
`endif
    output logic [WIDTH-1:0] o_rdata
);

    // No reset on the array or read registers so this maps onto SRAM.
    logic [WIDTH-1:0] r_mem [ENTRIES];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_en) begin
            r_mem[i_waddr] <= i_wdata;
            r_rdata        <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

`ifdef PDL_TAP_EN
    logic [WIDTH-1:0] r_rdata2;

    always_ff @(posedge clk) begin
        if (i_en) begin
            r_rdata2 <= r_mem[i_raddr2];
        end
    end

    assign o_rdata2 = r_rdata2;
`endif

endmodule

// File: rtl/prog_delay_line.sv
// Runtime-programmable delay line on a circular buffer with fill tracking.
// Define PDL_TAP_EN for the extra tap read port (tap_cfg/tap_out/tap_valid).
module prog_delay_line
    import prog_delay_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 1024,
    parameter int RESET_DELAY = DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       cfg_load,
    input  logic [$clog2(DEPTH+1)-1:0] delay_cfg,
`ifdef PDL_TAP_EN
    input  logic [$clog2(DEPTH+1)-1:0] tap_cfg,
    output logic [WIDTH-1:0]           tap_out,
    output logic                       tap_valid,
`endif
    output logic [WIDTH-1:0]           data_out,
    output logic                       out_valid,
    output logic                       busy
);

    localparam int CW      = $clog2(DEPTH + 1);
    localparam int ENTRIES = DEPTH - 1;
    localparam int PW      = ptr_width(ENTRIES);

    localparam logic [CW-1:0] C_DEPTH   = CW'(DEPTH);
    localparam logic [CW-1:0] C_RST_DLY = CW'(RESET_DELAY);
    localparam logic [CW-1:0] C_ONE     = CW'(1);
    localparam logic [PW-1:0] C_LAST    = PW'(DEPTH - 2);

    pdl_state_e       r_state;
    pdl_state_e       w_state_nxt;
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    w_wptr_nxt;
    logic [PW-1:0]    w_raddr;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [CW-1:0]    r_delay;
    logic [CW-1:0]    w_delay;
    logic             w_load;
    logic [WIDTH-1:0] r_byp;
    logic             r_byp_sel;
    logic [WIDTH-1:0] w_rdata;

    // Slot holding the sample written dly-1 enabled edges ago, mod ENTRIES.
    function automatic logic [PW-1:0] back_addr(input logic [PW-1:0] wp,
                                                input logic [CW-1:0] dly);
        logic [CW:0] back;
        logic [CW:0] wpx;
        back = {1'b0, dly} - (CW+1)'(1);
        wpx  = (CW+1)'(wp);
        if (wpx >= back) begin
            return PW'(wpx - back);
        end
        return PW'(wpx + (CW+1)'(ENTRIES) - back);
    endfunction

    assign w_load  = en & cfg_load;
    assign w_delay = w_load ? CW'(clamp(32'(delay_cfg), 32'd1, 32'(DEPTH)))
                            : r_delay;

    assign w_cnt_nxt = w_load             ? C_ONE :
                       (r_cnt == C_DEPTH) ? r_cnt :
                                            r_cnt + C_ONE;

    assign w_wptr_nxt = (r_wptr == C_LAST) ? '0 : r_wptr + PW'(1);
    assign w_raddr    = back_addr(r_wptr, w_delay);

    always_comb begin
        w_state_nxt = r_state;
        if (en) begin
            unique case (r_state)
                ST_FILL: begin
                    if (w_cnt_nxt >= w_delay) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_load && (w_delay != C_ONE)) begin
                        w_state_nxt = ST_FILL;
                    end
                end
                default: w_state_nxt = ST_FILL;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A delay of one bypasses the buffer through r_byp.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr    <= '0;
            r_cnt     <= '0;
            r_delay   <= C_RST_DLY;
            r_byp     <= '0;
            r_byp_sel <= 1'b0;
        end else if (en) begin
            r_wptr    <= w_wptr_nxt;
            r_cnt     <= w_cnt_nxt;
            r_delay   <= w_delay;
            r_byp     <= data_in;
            r_byp_sel <= (w_delay == C_ONE);
        end
    end

`ifdef PDL_TAP_EN
    logic [CW-1:0]    w_tdly;
    logic [PW-1:0]    w_traddr;
    logic [WIDTH-1:0] w_trdata;
    logic             r_tvalid;
    logic             r_tsel;

    assign w_tdly   = CW'(clamp(32'(tap_cfg), 32'd1, 32'(w_delay)));
    assign w_traddr = back_addr(r_wptr, w_tdly);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tvalid <= 1'b0;
            r_tsel   <= 1'b0;
        end else if (en) begin
            r_tvalid <= (w_cnt_nxt >= w_tdly);
            r_tsel   <= (w_tdly == C_ONE);
        end
    end

    assign tap_valid = r_tvalid;
    assign tap_out   = r_tvalid ? (r_tsel ? r_byp : w_trdata) : '0;
`endif

    pdl_ram #(
        .WIDTH   (WIDTH),
        .ENTRIES (ENTRIES),
        .AW      (PW)
    ) u_ram (
        .clk      (clk),
        .i_en     (en),
        .i_waddr  (r_wptr),
        .i_wdata  (data_in),
        .i_raddr  (w_raddr),
`ifdef PDL_TAP_EN
        .i_raddr2 (w_traddr),
        .o_rdata2 (w_trdata),
`endif
        .o_rdata  (w_rdata)
    );

    assign out_valid = (r_state == ST_RUN);
    assign busy      = (r_state == ST_FILL);
    assign data_out  = out_valid ? (r_byp_sel ? r_byp : w_rdata) : '0;

endmodule

// File: tb/tb_prog_delay_line.sv
// Randomised bench for prog_delay_line against a queue-based delay model.
// Tap port checks are included when PDL_TAP_EN is defined.
module tb_prog_delay_line;

    localparam int W  = 8;
    localparam int D  = 16;
    localparam int CW = $clog2(D + 1);

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          en        = 1'b0;
    logic          cfg_load  = 1'b0;
    logic [W-1:0]  data_in   = '0;
    logic [CW-1:0] delay_cfg = '0;
    logic [W-1:0]  data_out;
    logic          out_valid;
    logic          busy;
`ifdef PDL_TAP_EN
    logic [CW-1:0] tap_cfg = '0;
    logic [W-1:0]  tap_out;
    logic          tap_valid;
`endif

    int tests = 0;
    int fails = 0;

    logic [W-1:0] hist[$];
    int           fill     = 0;
    int           mdly     = D;
    int           tcfg     = 0;
    logic [W-1:0] e_data   = '0;
    logic         e_valid  = 1'b0;
    logic [W-1:0] e_tap    = '0;
    logic         e_tvalid = 1'b0;

    always #5 clk = ~clk;

    prog_delay_line #(
        .WIDTH       (W),
        .DEPTH       (D),
        .RESET_DELAY (D)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .data_in   (data_in),
        .cfg_load  (cfg_load),
        .delay_cfg (delay_cfg),
`ifdef PDL_TAP_EN
        .tap_cfg   (tap_cfg),
        .tap_out   (tap_out),
        .tap_valid (tap_valid),
`endif
        .data_out  (data_out),
        .out_valid (out_valid),
        .busy      (busy)
    );

    function automatic int clampi(int v, int lo, int hi);
        return (v < lo) ? lo : (v > hi) ? hi : v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        fill     = 0;
        mdly     = D;
        e_data   = '0;
        e_valid  = 1'b0;
        e_tap    = '0;
        e_tvalid = 1'b0;
    endtask

    // Output after an enabled edge is the sample taken mdly-1 edges earlier.
    task automatic model_edge(logic [W-1:0] d, bit ld, int cfg);
        int tdly;
        hist.push_back(d);
        if (hist.size() > 64) void'(hist.pop_front());
        if (ld) begin
            mdly = clampi(cfg, 1, D);
            fill = 1;
        end else if (fill < D) begin
            fill++;
        end
        e_valid  = (fill >= mdly);
        e_data   = e_valid ? hist[hist.size() - mdly] : '0;
        tdly     = clampi(tcfg, 1, mdly);
        e_tvalid = (fill >= tdly);
        e_tap    = e_tvalid ? hist[hist.size() - tdly] : '0;
    endtask

    task automatic check_all();
        chk("data_out", 32'(data_out), 32'(e_data));
        chk("out_valid", 32'(out_valid), 32'(e_valid));
        chk("busy", 32'(busy), 32'(!e_valid));
`ifdef PDL_TAP_EN
        chk("tap_out", 32'(tap_out), 32'(e_tap));
        chk("tap_valid", 32'(tap_valid), 32'(e_tvalid));
`endif
    endtask

    task automatic step(bit e, logic [W-1:0] d, bit ld, int cfg);
        en        = e;
        data_in   = d;
        cfg_load  = ld;
        delay_cfg = CW'(cfg);
`ifdef PDL_TAP_EN
        tap_cfg   = CW'(tcfg);
`endif
        @(posedge clk);
        if (e) model_edge(d, ld, cfg);
        #1;
        check_all();
    endtask

    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_data", 32'(data_out), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h1);
`ifdef PDL_TAP_EN
        chk("rst_tvalid", 32'(tap_valid), 32'h0);
`endif
        model_reset();
        #2;
        rst = 1'b0;
    endtask

    task automatic count_edges(bit ld, int cfg, output int o_first, output int t_first);
        o_first = 0;
        t_first = 0;
        for (int i = 1; i <= 24 && o_first == 0; i++) begin
            step(1'b1, W'(i * 3), ld && (i == 1), cfg);
            if (out_valid && o_first == 0) o_first = i;
`ifdef PDL_TAP_EN
            if (tap_valid && t_first == 0) t_first = i;
`endif
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int of;
        int tf;
        model_reset();
        #3;
        chk("init_data", 32'(data_out), 32'h0);
        chk("init_valid", 32'(out_valid), 32'h0);
        chk("init_busy", 32'(busy), 32'h1);
        #5;
        rst = 1'b0;

        for (int i = 1; i <= 16; i++) begin
            step(1'b1, W'(i), 1'b0, 0);
            if (i == 15) chk("fill15_valid", 32'(out_valid), 32'h0);
        end
        chk("fill16_data", 32'(data_out), 32'h1);
        chk("fill16_valid", 32'(out_valid), 32'h1);
        chk("fill16_busy", 32'(busy), 32'h0);
        step(1'b1, W'(17), 1'b0, 0);
        chk("run17_data", 32'(data_out), 32'h2);
        for (int i = 18; i <= 20; i++) step(1'b1, W'(i), 1'b0, 0);

        step(1'b1, 8'hA5, 1'b1, 1);
        chk("d1_data", 32'(data_out), 32'hA5);
        chk("d1_valid", 32'(out_valid), 32'h1);
        step(1'b1, 8'h33, 1'b0, 0);
        step(1'b1, 8'hA5, 1'b1, 0);
        chk("d0_data", 32'(data_out), 32'hA5);
        chk("d0_valid", 32'(out_valid), 32'h1);

        step(1'b1, 8'h10, 1'b1, 5);
        for (int i = 1; i <= 63; i++) begin
            step(1'b1, W'(8'h10 + (i % 16)), 1'b0, 0);
            if (i == 3) chk("d5_edge4_valid", 32'(out_valid), 32'h0);
            if (i == 4) chk("d5_edge5_data", 32'(data_out), 32'h10);
        end

        step(1'b1, W'($urandom), 1'b1, 7);
        for (int i = 0; i < 200; i++) begin
            step(($urandom_range(99) >= 40), W'($urandom), 1'b0, 0);
        end

        for (int i = 0; i < 300; i++) begin
            tcfg = $urandom_range(20);
            step(($urandom_range(99) >= 30), W'($urandom),
                 ($urandom_range(99) < 6), $urandom_range(20));
        end
        tcfg = 0;

        step(1'b1, 8'h01, 1'b1, 3);
        for (int i = 0; i < 5; i++) step(1'b1, W'(i), 1'b0, 0);
        async_reset();
        count_edges(1'b0, 0, of, tf);
        chk("refill_run_edges", 32'(of), 32'd16);

        for (int i = 0; i < 5; i++) step(1'b1, W'(i), 1'b0, 0);
        async_reset();
        for (int i = 0; i < 5; i++) step(1'b1, W'(i + 40), 1'b0, 0);
        async_reset();
        count_edges(1'b0, 0, of, tf);
        chk("refill_fill_edges", 32'(of), 32'd16);

        count_edges(1'b1, 20, of, tf);
        chk("clamp20_edges", 32'(of), 32'd16);

`ifdef PDL_TAP_EN
        tcfg = 4;
        count_edges(1'b1, 12, of, tf);
        chk("tap4_edges", 32'(tf), 32'd4);
        chk("tap4_out_edges", 32'(of), 32'd12);
        for (int i = 0; i < 30; i++) step(1'b1, W'($urandom), 1'b0, 0);
        tcfg = 15;
        count_edges(1'b1, 12, of, tf);
        chk("tap15_edges", 32'(tf), 32'd12);
        for (int i = 0; i < 30; i++) step(1'b1, W'($urandom), 1'b0, 0);
        tcfg = 0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
